// File: rtl/i3c_arb_pkg.sv
// Shared types for the I3C IBI/MR bus arbiter: FSM states, request type and
// the winner record produced by the address-arbitration selector.
package i3c_arb_pkg;

    // Sized for the largest supported configuration (16 agents, 10-bit addresses)
    localparam int IDX_MAX_W  = 4;
    localparam int ADDR_MAX_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        PRESENT,
        GRANTED,
        COOLDOWN
    } arb_state_e;

    typedef enum logic {
        REQ_IBI,
        REQ_MR
    } req_type_e;

    typedef struct packed {
        logic [IDX_MAX_W-1:0]  idx;
        logic [ADDR_MAX_W-1:0] addr;
        logic                  is_mr;
        logic                  valid;
    } winner_t;

endpackage

// File: rtl/i3c_arb_select.sv
// Combinational address arbitration: lowest {dyn_addr, RnW} among eligible agents
// wins, so MR (RnW=0) beats IBI at the same address; ties go to the lowest index.
module i3c_arb_select
    import i3c_arb_pkg::*;
#(
    parameter int NUM_AGENTS = 4,
    parameter int ADDR_W     = 7
) (
    input  logic [NUM_AGENTS-1:0]        eligible,
    input  logic [NUM_AGENTS-1:0]        mr_req,
    input  logic [NUM_AGENTS*ADDR_W-1:0] dyn_addr,
    output winner_t                      winner
);

    logic [ADDR_W:0] best_key;
    logic [ADDR_W:0] cand_key;

    // Strict less-than while scanning upward keeps the lowest index on equal keys
    always_comb begin
        winner   = '0;
        best_key = '1;
        cand_key = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            cand_key = {dyn_addr[i*ADDR_W +: ADDR_W], ~mr_req[i]};
            if (eligible[i] && (!winner.valid || cand_key < best_key)) begin
                best_key     = cand_key;
                winner.valid = 1'b1;
                winner.idx   = IDX_MAX_W'(i);
                winner.addr  = ADDR_MAX_W'(dyn_addr[i*ADDR_W +: ADDR_W]);
                winner.is_mr = mr_req[i];
            end
        end
    end

endmodule

// File: rtl/i3c_bus_arbiter.sv
// I3C IBI / Mastership-Request arbiter: picks a winner, presents it to the primary
// master, runs ACK/NACK, grant/release, per-agent NACK backoff and bus-free gap.
module i3c_bus_arbiter
    import i3c_arb_pkg::*;
#(
    parameter int NUM_AGENTS      = 4,
    parameter int ADDR_W          = 7,
    parameter int ACK_TIMEOUT     = 64,
    parameter int BACKOFF_CYCLES  = 32,
    parameter int BUS_FREE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_AGENTS-1:0]         ibi_req,
    input  logic [NUM_AGENTS-1:0]         mr_req,
    input  logic [NUM_AGENTS-1:0]         agent_en,
    input  logic [NUM_AGENTS*ADDR_W-1:0]  dyn_addr,
    input  logic                          bus_idle,
    input  logic                          host_ack,
    input  logic                          host_nack,
    input  logic [NUM_AGENTS-1:0]         mr_release,
    output logic                          arb_valid,
    output logic [ADDR_W-1:0]             arb_addr,
    output logic                          arb_is_mr,
    output logic [$clog2(NUM_AGENTS)-1:0] arb_idx,
    output logic [NUM_AGENTS-1:0]         ibi_ack,
    output logic [NUM_AGENTS-1:0]         ibi_nack,
    output logic [NUM_AGENTS-1:0]         master_granted,
    output logic                          timeout,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_AGENTS);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int CF_W  = $clog2(BUS_FREE_CYCLES + 1);
    localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CF_W-1:0]  COOL_LAST = CF_W'(BUS_FREE_CYCLES - 1);
    localparam logic [BO_W-1:0]  BO_LOAD   = BO_W'(BACKOFF_CYCLES);

    arb_state_e            state, state_d;
    logic [ACK_W-1:0]      ack_cnt, ack_cnt_d;
    logic [CF_W-1:0]       cool_cnt, cool_cnt_d;
    logic [BO_W-1:0]       backoff_cnt [NUM_AGENTS];
    logic [NUM_AGENTS-1:0] eligible;
    winner_t               win;
    logic                  win_unused;
    logic [IDX_W-1:0]      win_idx, win_idx_d;
    logic [ADDR_W-1:0]     win_addr, win_addr_d;
    req_type_e             win_type, win_type_d;
    logic                  req_held;
    logic                  nack_set;
    logic                  arb_valid_d, timeout_d;
    logic [NUM_AGENTS-1:0] ibi_ack_d, ibi_nack_d, granted_d;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            eligible[i] = (ibi_req[i] | mr_req[i]) & agent_en[i] & (backoff_cnt[i] == '0);
        end
    end

    i3c_arb_select #(
        .NUM_AGENTS (NUM_AGENTS),
        .ADDR_W     (ADDR_W)
    ) u_select (
        .eligible (eligible),
        .mr_req   (mr_req),
        .dyn_addr (dyn_addr),
        .winner   (win)
    );

    assign win_unused = ^{win.idx, win.addr};
    assign req_held   = (win_type == REQ_MR) ? mr_req[win_idx] : ibi_req[win_idx];

    // A host response always outranks a withdrawal seen in the same cycle
    always_comb begin
        state_d     = state;
        ack_cnt_d   = ack_cnt;
        cool_cnt_d  = cool_cnt;
        win_idx_d   = win_idx;
        win_addr_d  = win_addr;
        win_type_d  = win_type;
        arb_valid_d = arb_valid;
        granted_d   = master_granted;
        timeout_d   = 1'b0;
        ibi_ack_d   = '0;
        ibi_nack_d  = '0;
        nack_set    = 1'b0;
        case (state)
            IDLE: begin
                if (bus_idle && (|eligible)) state_d = ARB;
            end
            ARB: begin
                if (win.valid) begin
                    win_idx_d   = win.idx[IDX_W-1:0];
                    win_addr_d  = win.addr[ADDR_W-1:0];
                    win_type_d  = win.is_mr ? REQ_MR : REQ_IBI;
                    ack_cnt_d   = '0;
                    arb_valid_d = 1'b1;
                    state_d     = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                ack_cnt_d = ack_cnt + 1'b1;
                if (host_nack || (!host_ack && ack_cnt == ACK_LAST)) begin
                    ibi_nack_d[win_idx] = 1'b1;
                    timeout_d           = !host_nack;
                    nack_set            = 1'b1;
                    arb_valid_d         = 1'b0;
                    cool_cnt_d          = '0;
                    state_d             = COOLDOWN;
                end else if (host_ack) begin
                    arb_valid_d = 1'b0;
                    if (win_type == REQ_MR) begin
                        granted_d[win_idx] = 1'b1;
                        state_d            = GRANTED;
                    end else begin
                        ibi_ack_d[win_idx] = 1'b1;
                        cool_cnt_d         = '0;
                        state_d            = COOLDOWN;
                    end
                end else if (!req_held) begin
                    arb_valid_d = 1'b0;
                    cool_cnt_d  = '0;
                    state_d     = COOLDOWN;
                end
            end
            GRANTED: begin
                if (mr_release[win_idx]) begin
                    granted_d  = '0;
                    cool_cnt_d = '0;
                    state_d    = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cool_cnt == COOL_LAST) state_d = IDLE;
                else cool_cnt_d = cool_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ack_cnt        <= '0;
            cool_cnt       <= '0;
            win_idx        <= '0;
            win_addr       <= '0;
            win_type       <= REQ_IBI;
            arb_valid      <= 1'b0;
            timeout        <= 1'b0;
            ibi_ack        <= '0;
            ibi_nack       <= '0;
            master_granted <= '0;
        end else begin
            state          <= state_d;
            ack_cnt        <= ack_cnt_d;
            cool_cnt       <= cool_cnt_d;
            win_idx        <= win_idx_d;
            win_addr       <= win_addr_d;
            win_type       <= win_type_d;
            arb_valid      <= arb_valid_d;
            timeout        <= timeout_d;
            ibi_ack        <= ibi_ack_d;
            ibi_nack       <= ibi_nack_d;
            master_granted <= granted_d;
        end
    end

    // Backoff counters run in every state; a NACK reloads the loser's counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_AGENTS; i++) backoff_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_AGENTS; i++) begin
                if (nack_set && win_idx == IDX_W'(i)) backoff_cnt[i] <= BO_LOAD;
                else if (backoff_cnt[i] != '0)        backoff_cnt[i] <= backoff_cnt[i] - 1'b1;
            end
        end
    end

    assign arb_addr  = win_addr;
    assign arb_is_mr = (win_type == REQ_MR);
    assign arb_idx   = win_idx;
    assign busy      = (state != IDLE);

endmodule
